// File: rtl/writeback_stage.sv
// Writeback stage: retires instructions from the memory stage, extracts and
// extends load data, and drives the register-file write port from registers.
module writeback_stage #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 6,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              m_valid,
    output logic              m_ready,
    input  logic [4:0]        m_rd,
    input  logic              m_reg_write,
    input  logic [1:0]        m_wb_sel,
    input  logic [2:0]        m_funct3,
    input  logic [XLEN-1:0]   m_alu_result,
    input  logic [XLEN-1:0]   m_pc_plus4,
    input  logic              dmem_rvalid,
    input  logic [XLEN-1:0]   dmem_rdata,
    output logic [ADDR_W-1:0] rf_a3,
    output logic              rf_we3,
    output logic [XLEN-1:0]   rf_wd3,
    output logic              retire,
    output logic              misalign_err,
    output logic [CNT_W-1:0]  retire_cnt
);

    typedef enum logic [0:0] {
        IDLE     = 1'b0,
        WAIT_MEM = 1'b1
    } state_t;

    state_t state, state_next;

    // Load context captured at accept time, used once the data word arrives
    logic [4:0] ld_rd;
    logic       ld_reg_write;
    logic [2:0] ld_funct3;
    logic [1:0] ld_off;

    logic            accept;
    logic            is_load;
    logic [7:0]      ld_byte;
    logic [15:0]     ld_half;
    logic [XLEN-1:0] ld_value;
    logic            ld_misaligned;
    logic [XLEN-1:0] direct_value;
    logic            do_retire;
    logic            do_write;
    logic            do_mis;
    logic [4:0]      wr_rd;
    logic [XLEN-1:0] wr_data;

    assign m_ready = (state == IDLE);
    assign accept  = m_valid && m_ready;
    assign is_load = (m_wb_sel == 2'b01);

    // Pick the addressed byte/halfword, extend it, and flag misaligned accesses
    always_comb begin
        ld_byte       = dmem_rdata[{ld_off, 3'b000} +: 8];
        ld_half       = ld_off[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        ld_value      = dmem_rdata;
        ld_misaligned = 1'b0;
        case (ld_funct3)
            3'b000: ld_value = {{(XLEN-8){ld_byte[7]}}, ld_byte};
            3'b100: ld_value = {{(XLEN-8){1'b0}}, ld_byte};
            3'b001: begin
                ld_value      = {{(XLEN-16){ld_half[15]}}, ld_half};
                ld_misaligned = ld_off[0];
            end
            3'b101: begin
                ld_value      = {{(XLEN-16){1'b0}}, ld_half};
                ld_misaligned = ld_off[0];
            end
            default: ld_misaligned = (ld_off != 2'b00);
        endcase
    end

    // Non-load writeback source: link value for 10, ALU result otherwise
    always_comb begin
        case (m_wb_sel)
            2'b10:   direct_value = m_pc_plus4;
            default: direct_value = m_alu_result;
        endcase
    end

    // Next-state and next-output decisions for the two-state controller
    always_comb begin
        state_next = state;
        do_retire  = 1'b0;
        do_write   = 1'b0;
        do_mis     = 1'b0;
        wr_rd      = m_rd;
        wr_data    = direct_value;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (is_load) begin
                        state_next = WAIT_MEM;
                    end else begin
                        do_retire = 1'b1;
                        do_write  = m_reg_write && (m_rd != 5'd0);
                    end
                end
            end
            WAIT_MEM: begin
                wr_rd   = ld_rd;
                wr_data = ld_value;
                if (dmem_rvalid) begin
                    state_next = IDLE;
                    do_retire  = 1'b1;
                    do_mis     = ld_misaligned;
                    do_write   = ld_reg_write && (ld_rd != 5'd0) && !ld_misaligned;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Capture load context when a load is accepted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ld_rd        <= 5'd0;
            ld_reg_write <= 1'b0;
            ld_funct3    <= 3'd0;
            ld_off       <= 2'd0;
        end else if (accept && is_load) begin
            ld_rd        <= m_rd;
            ld_reg_write <= m_reg_write;
            ld_funct3    <= m_funct3;
            ld_off       <= m_alu_result[1:0];
        end
    end

    // Registered write port and pulses; address/data hold unless a write occurs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_we3       <= 1'b0;
            rf_a3        <= '0;
            rf_wd3       <= '0;
            retire       <= 1'b0;
            misalign_err <= 1'b0;
        end else begin
            rf_we3       <= do_write;
            retire       <= do_retire;
            misalign_err <= do_mis;
            if (do_write) begin
                rf_a3  <= ADDR_W'(wr_rd);
                rf_wd3 <= wr_data;
            end
        end
    end

    // Retired-instruction counter, wraps naturally at its width
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retire_cnt <= '0;
        end else if (do_retire) begin
            retire_cnt <= retire_cnt + CNT_W'(1);
        end
    end

endmodule

// File: doc/writeback_stage.md
Name: writeback_stage

Overview:
- Final pipeline stage of the processor core.
- Accepts retiring instructions from the memory stage, waits for load data where required, and performs load byte/halfword extraction and sign/zero extension.
- Selects the writeback value and drives the register file write port (address, write enable, write data) from registered outputs.
- Also exports a retire pulse, a misalignment error pulse and a retired-instruction counter.

Parameters:
- XLEN, 32, data width of results, load data and register-file write data
- ADDR_W, 6, width of register-file address ports; upper bits above bit 4 are driven zero
- CNT_W, 32, width of the retired-instruction counter

Ports:
- clk  input  1  core clock; all state changes on rising edge
- rst_n  input  1  asynchronous active-low reset
- m_valid  input  1  memory stage presents an instruction
- m_ready  output  1  stage can accept; transfer occurs when m_valid && m_ready
- m_rd  input  5  destination register index
- m_reg_write  input  1  instruction writes a register
- m_wb_sel  input  2  00 ALU result, 01 load data, 10 PC+4, 11 treated as 00
- m_funct3  input  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; other codes treated as LW
- m_alu_result  input  XLEN  ALU result; also the load byte address
- m_pc_plus4  input  XLEN  link value
- dmem_rvalid  input  1  load data valid
- dmem_rdata  input  XLEN  aligned word containing the load
- rf_a3  output  ADDR_W  register-file write address
- rf_we3  output  1  register-file write enable
- rf_wd3  output  XLEN  register-file write data
- retire  output  1  one-cycle pulse per completed instruction
- misalign_err  output  1  one-cycle pulse on a misaligned load
- retire_cnt  output  CNT_W  count of retired instructions

Behaviour:
- Reset (asynchronous, rst_n low):
  - State goes to IDLE.
  - rf_we3, retire and misalign_err are 0; rf_a3, rf_wd3 and retire_cnt are 0.
  - Any pending load is discarded. Reset is effective immediately, including in WAIT_MEM.
- States: IDLE, WAIT_MEM. m_ready = 1 in IDLE and 0 in WAIT_MEM (combinational from state).
- IDLE, accept with m_wb_sel != 01:
  - Next cycle: rf_we3 = m_reg_write && (m_rd != 0), rf_a3 = zero-extended m_rd, rf_wd3 = selected value, retire = 1.
  - State stays IDLE. Back-to-back accepts give one write per cycle.
- IDLE, accept with m_wb_sel == 01:
  - Latch rd, reg_write, funct3 and alu_result[1:0] into the stage; go to WAIT_MEM.
  - Next cycle: rf_we3 = 0, retire = 0.
- WAIT_MEM:
  - dmem_rvalid is sampled only in this state; minimum load latency is 1 cycle. dmem_rvalid outside WAIT_MEM is ignored.
  - On dmem_rvalid: return to IDLE. Next cycle, write the extracted value under the same rd/reg_write rules and pulse retire.
- Load extraction, using byte offset off = latched alu_result[1:0]:
  - LB/LBU take byte dmem_rdata[8*off+7 : 8*off], sign-extended or zero-extended.
  - LH/LHU take halfword off[1] (off must be 0 or 2), sign-extended or zero-extended.
  - LW requires off = 0.
- Misaligned load (LH/LHU with off odd; LW with off != 0):
  - The stage still waits for dmem_rvalid.
  - Next cycle: rf_we3 = 0, misalign_err = 1, retire = 1.
- rd = 0: the instruction retires normally with rf_we3 forced to 0. The stage itself never writes x0.
- m_reg_write = 0: the instruction retires with rf_we3 = 0; for loads the stage still waits for data.
- rf_a3 and rf_wd3 hold their last values when rf_we3 = 0.
- retire_cnt increments by 1 on each retire pulse and wraps modulo 2^CNT_W.
- retire and misalign_err are never high for more than one cycle per instruction.

Test Plan:
- Reset then ALU op: m_rd=5, wb_sel=00, alu_result=0x1234_5678, reg_write=1 -> next cycle rf_we3=1, rf_a3=5, rf_wd3=0x12345678, retire=1, retire_cnt=1.
- Back-to-back: JAL with rd=1, pc_plus4=0x104 on cycle N, then ALU op with rd=2, result 7 on N+1 -> writes (1,0x104) at N+1 and (2,7) at N+2; m_ready stays 1 throughout.
- LB: alu_result=0x1001, dmem_rvalid 3 cycles after accept, rdata=0x0000_8000 -> m_ready=0 for 3 cycles; then rf_wd3=0xFFFF_FF80 and rf_we3=1 one cycle after rvalid.
- LHU: off=2, rdata=0xBEEF_0000 -> rf_wd3=0x0000_BEEF. Same load as LH -> rf_wd3=0xFFFF_BEEF.
- Misaligned LW (alu_result=0x2002) -> after rvalid, misalign_err=1, retire=1, rf_we3=0. Also: ALU op to rd=0 -> rf_we3=0, retire=1.
- Assert rst_n low while in WAIT_MEM -> m_ready=1 immediately, retire_cnt=0; a subsequent dmem_rvalid produces no write.
